float_to_int_pipe: RTL and testbench
====================================

FLOAT_TO_INT_PIPE -- requirements
Module: float_to_int_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent width of the input float.
REQ-002 Parameter MAN_W, default 23, stored mantissa width (hidden bit excluded).
REQ-003 Parameter OUT_W, default 32, integer result width, >= 2.
REQ-004 Parameter SIGNED, default 0; 0 gives an unsigned result, 1 gives a two's-complement result.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: synchronous, active-low reset.
REQ-007 Port a, input, 1+EXP_W+MAN_W: IEEE-style float operand (sign, exponent, mantissa).
REQ-008 Port rnd, input, 1: rounding mode sampled with a; 0 truncates toward zero, 1 rounds to nearest, ties to even.
REQ-009 Port in_valid, input, 1, and port in_ready, output, 1: the input handshake.
REQ-010 Port z, output, OUT_W: integer result.
REQ-011 Port out_valid, output, 1, and port out_ready, input, 1: the output handshake.
REQ-012 Ports ovf, inv, inx, outputs, 1 each: overflow/saturated, invalid (NaN), and inexact flags, qualified by out_valid.

Function
REQ-013 A transfer shall occur only when valid and ready are both high in the same cycle.
REQ-014 Three pipeline stages: S1 unpack/classify, S2 align shift with sticky, S3 round/saturate/negate.
REQ-015 Latency shall be exactly 3 cycles from input transfer to out_valid when out_ready is held high.
REQ-016 Throughput shall be one result per cycle with no bubbles while out_ready is high.
REQ-017 Stall rule: in_ready = !out_valid | out_ready; when it is low, all stage registers shall hold.
REQ-018 Results shall leave in acceptance order; no operand shall be lost or duplicated under any pattern of backpressure.
REQ-019 z and the flags shall remain stable while out_valid=1 and out_ready=0.
REQ-020 Value = (-1)^s * 1.m * 2^(e-bias), with bias = 2^(EXP_W-1)-1; the shift is clamped to OUT_W+2 positions; bits shifted out feed guard and sticky.
REQ-021 inx=1 whenever any nonzero fraction bit is discarded and the result is not saturated.
REQ-022 Zero exponent (zero or subnormal) -> z=0; inx=1 if the mantissa is nonzero; -0 -> z=0 with no flags.
REQ-023 NaN (max exponent, mantissa != 0) -> inv=1; z = max representable value (unsigned all-ones; signed 2^(OUT_W-1)-1).
REQ-024 +Inf, or a rounded magnitude above the max -> z=max, ovf=1.
REQ-025 Signed mode: -Inf, or a rounded value below -2^(OUT_W-1) -> z = 2^(OUT_W-1) as a bit pattern, ovf=1; exactly -2^(OUT_W-1) shall not overflow.
REQ-026 Unsigned mode, negative input: if it rounds to 0, z=0 with inx as per REQ-021; otherwise z=0, ovf=1.
REQ-027 Rounding may carry into a new MSB; the overflow check shall be applied after rounding.
REQ-028 At most one of ovf and inv shall be set; inx shall be 0 whenever ovf or inv is 1.

Reset
REQ-029 While rst_n=0 at a clock edge, all stage valid bits clear; out_valid=0, z=0, ovf=inv=inx=0.
REQ-030 in_ready shall be 1 during reset and in the first cycle after reset.
REQ-031 Reset mid-operation discards all in-flight operands; no out_valid until a new operand is accepted after reset.

Structure
REQ-032 A shared package shall define the class codes (ZERO, NORM, INF, NAN) and helper constants for bias and the max/min integer patterns.
REQ-033 One sub-module, fti_shift_sticky: combinational right shifter returning the shifted value, guard bit and sticky bit; instantiated in S2.
REQ-034 No other sub-modules; the handshake logic shall be flat in float_to_int_pipe.

Verification (defaults unless noted)
REQ-035 a=0x3FC00000 (1.5): rnd=1 -> z=2, inx=1; rnd=0 -> z=1, inx=1. a=0x40200000 (2.5), rnd=1 -> z=2 (tie to even).
REQ-036 a=0x4F7FFFFF -> z=0xFFFFFF00, no flags; a=0x4F800000 -> z=0xFFFFFFFF, ovf=1; a=0x7FC00000 -> z=0xFFFFFFFF, inv=1.
REQ-037 a=0xBF800000 (-1.0): unsigned -> z=0, ovf=1; SIGNED=1 -> z=0xFFFFFFFF, no flags; SIGNED=1 with a=0xCF000000 -> z=0x80000000, no flags.
REQ-038 Stream 6 operands with out_ready=0 for cycles 2-6 -> in_ready drops once 3 are held; all 6 results arrive in order, bit-exact against the reference model.
REQ-039 rst_n=0 for 1 cycle with 3 operands in flight -> out_valid=0 next cycle, no stale results; a fresh operand gives a result 3 cycles after acceptance.
REQ-040 Random regression of 10,000 operands with random rnd and out_ready -> z and flags match the golden model for both SIGNED settings.

Source files
------------

// File: rtl/float_to_int_pipe_pkg.sv
// float_to_int_pipe_pkg: class codes and bias/saturation constant helpers for the float-to-int pipeline
package float_to_int_pipe_pkg;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_e;
  localparam int MAX_W = 64;
  localparam logic [MAX_W:0] ONE = (MAX_W + 1)'(1);
  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [MAX_W:0] max_of(input int out_w, input bit sgn);
    return (ONE << (sgn ? out_w - 1 : out_w)) - ONE;
  endfunction
  function automatic logic [MAX_W:0] min_of(input int out_w, input bit sgn);
    return sgn ? ONE << (out_w - 1) : '0;
  endfunction
endpackage

// File: rtl/float_to_int_pipe_shift.sv
// fti_shift_sticky: right shifter returning the shifted value plus guard and sticky bits
module fti_shift_sticky #(
  parameter int W = 33,
  parameter int SW = 6
) (
  input  logic [W-1:0]  val,
  input  logic [SW-1:0] sh,
  output logic [W-1:0]  res,
  output logic          guard,
  output logic          sticky
);
  logic [2*W:0] t;
  assign t = {val, {(W + 1){1'b0}}} >> sh;
  assign res = t[2*W:W+1];
  assign guard = t[W];
  assign sticky = |t[W-1:0];
endmodule

// File: rtl/float_to_int_pipe.sv
// float_to_int_pipe: three-stage float to integer converter with rounding, saturation and stall handshake
module float_to_int_pipe
  import float_to_int_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int OUT_W = 32,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic                   rnd,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf,
  output logic                   inv,
  output logic                   inx
);
  localparam int MW = MAN_W + 1;
  localparam int VW = OUT_W + 1;
  localparam int SHW = $clog2(OUT_W + 3);
  localparam int BIAS = bias_of(EXP_W);
  localparam logic [OUT_W-1:0] ZMAX = OUT_W'(max_of(OUT_W, SIGNED != 0));
  localparam logic [OUT_W-1:0] ZMIN = OUT_W'(min_of(OUT_W, SIGNED != 0));
  typedef struct packed {
    logic v;
    cls_e cls;
    logic sgn;
    logic rnd;
    logic sub;
    logic signed [31:0] e;
    logic [MW-1:0] m;
  } s1_t;
  typedef struct packed {
    logic v;
    cls_e cls;
    logic sgn;
    logic rnd;
    logic sub;
    logic big;
    logic [VW-1:0] mag;
    logic g;
    logic st;
  } s2_t;
  typedef struct packed {
    logic v;
    logic [OUT_W-1:0] z;
    logic ovf;
    logic inv;
    logic inx;
  } s3_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic en, big, up, frac, sh_g, sh_st;
  logic [EXP_W-1:0] ex;
  logic [MAN_W-1:0] mn;
  logic [MW+VW-1:0] cat;
  logic [VW-1:0] sh_res;
  logic [SHW-1:0] sh;
  logic [VW:0] rm;
  int e_s;
  assign en = !s3_q.v || out_ready;
  assign in_ready = en || !rst_n;
  assign ex = a[MAN_W +: EXP_W];
  assign mn = a[MAN_W-1:0];
  // mantissa MSB sits at weight 2^OUT_W; bits that do not fit go straight to sticky
  assign cat = {s1_q.m, {VW{1'b0}}};
  assign e_s = s1_q.e;
  assign big = e_s > OUT_W;
  assign sh = e_s < -1 ? SHW'(OUT_W + 2) : big ? '0 : SHW'(OUT_W - e_s);
  fti_shift_sticky #(.W(VW), .SW(SHW)) u_shift (
    .val(cat[MW+VW-1 -: VW]),
    .sh(sh),
    .res(sh_res),
    .guard(sh_g),
    .sticky(sh_st)
  );
  assign up = s2_q.rnd && s2_q.g && (s2_q.st || s2_q.mag[0]);
  assign rm = {1'b0, s2_q.mag} + {{VW{1'b0}}, up};
  assign frac = s2_q.g || s2_q.st;
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (en) begin
      s1_d.v = in_valid;
      s1_d.sgn = a[EXP_W+MAN_W];
      s1_d.rnd = rnd;
      s1_d.cls = &ex ? (|mn ? NAN : INF) : (|ex ? NORM : ZERO);
      s1_d.sub = ~|ex && |mn;
      s1_d.e = int'(ex) - BIAS;
      s1_d.m = {1'b1, mn};
      s2_d.v = s1_q.v;
      s2_d.cls = s1_q.cls;
      s2_d.sgn = s1_q.sgn;
      s2_d.rnd = s1_q.rnd;
      s2_d.sub = s1_q.sub;
      s2_d.big = big;
      s2_d.mag = sh_res;
      s2_d.g = sh_g;
      s2_d.st = sh_st || |cat[MW-1:0];
      s3_d.v = s2_q.v;
      s3_d.z = '0;
      s3_d.ovf = 1'b0;
      s3_d.inv = 1'b0;
      s3_d.inx = 1'b0;
      if (s2_q.cls == NAN) begin
        s3_d.z = ZMAX;
        s3_d.inv = 1'b1;
      end else if (s2_q.cls == INF) begin
        s3_d.z = s2_q.sgn ? ZMIN : ZMAX;
        s3_d.ovf = 1'b1;
      end else if (s2_q.cls == ZERO) begin
        s3_d.inx = s2_q.sub;
      end else if (s2_q.sgn && SIGNED == 0) begin
        s3_d.ovf = s2_q.big || rm != '0;
        s3_d.inx = !(s2_q.big || rm != '0) && frac;
      end else if (s2_q.sgn) begin
        s3_d.ovf = s2_q.big || rm > {2'b0, ZMIN};
        s3_d.z = s3_d.ovf ? ZMIN : OUT_W'(-rm);
        s3_d.inx = !s3_d.ovf && frac;
      end else begin
        s3_d.ovf = s2_q.big || rm > {2'b0, ZMAX};
        s3_d.z = s3_d.ovf ? ZMAX : rm[OUT_W-1:0];
        s3_d.inx = !s3_d.ovf && frac;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end
  assign out_valid = s3_q.v;
  assign z = s3_q.z;
  assign ovf = s3_q.ovf;
  assign inv = s3_q.inv;
  assign inx = s3_q.inx;
endmodule

// File: tb/tb_float_to_int_pipe.sv
// tb_float_to_int_pipe: random and directed checks of both signedness variants against an arithmetic model
module tb_float_to_int_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a = '0;
  logic rnd = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [31:0] z_u, z_s;
  logic ovf_u, inv_u, inx_u, ovf_s, inv_s, inx_s;
  always #5 clk = ~clk;
  float_to_int_pipe #(.SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .a(a), .rnd(rnd), .in_valid(in_valid), .in_ready(in_ready_u),
    .z(z_u), .out_valid(out_valid_u), .out_ready(out_ready), .ovf(ovf_u), .inv(inv_u), .inx(inx_u)
  );
  float_to_int_pipe #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .a(a), .rnd(rnd), .in_valid(in_valid), .in_ready(in_ready_s),
    .z(z_s), .out_valid(out_valid_s), .out_ready(out_ready), .ovf(ovf_s), .inv(inv_s), .inx(inx_s)
  );
  typedef struct {
    logic [31:0] z_u;
    logic [2:0] f_u;
    logic [31:0] z_s;
    logic [2:0] f_s;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    bit r;
    logic [31:0] zu;
    logic [2:0] fu;
    logic [31:0] zs;
    logic [2:0] fs;
  } dir_t;
  dir_t dirs [19] = '{
    '{32'h3FC00000, 1'b1, 32'h2, 3'b001, 32'h2, 3'b001},
    '{32'h3FC00000, 1'b0, 32'h1, 3'b001, 32'h1, 3'b001},
    '{32'h40200000, 1'b1, 32'h2, 3'b001, 32'h2, 3'b001},
    '{32'h4F7FFFFF, 1'b0, 32'hFFFFFF00, 3'b000, 32'h7FFFFFFF, 3'b100},
    '{32'h4F800000, 1'b0, 32'hFFFFFFFF, 3'b100, 32'h7FFFFFFF, 3'b100},
    '{32'h7FC00000, 1'b0, 32'hFFFFFFFF, 3'b010, 32'h7FFFFFFF, 3'b010},
    '{32'hBF800000, 1'b0, 32'h0, 3'b100, 32'hFFFFFFFF, 3'b000},
    '{32'hCF000000, 1'b0, 32'h0, 3'b100, 32'h80000000, 3'b000},
    '{32'h80000000, 1'b1, 32'h0, 3'b000, 32'h0, 3'b000},
    '{32'h00000001, 1'b1, 32'h0, 3'b001, 32'h0, 3'b001},
    '{32'hFF800000, 1'b0, 32'h0, 3'b100, 32'h80000000, 3'b100},
    '{32'hBF000000, 1'b1, 32'h0, 3'b001, 32'h0, 3'b001},
    '{32'hBFC00000, 1'b1, 32'h0, 3'b100, 32'hFFFFFFFE, 3'b001},
    '{32'hCF000001, 1'b0, 32'h0, 3'b100, 32'h80000000, 3'b100},
    '{32'h4EFFFFFF, 1'b0, 32'h7FFFFF80, 3'b000, 32'h7FFFFF80, 3'b000},
    '{32'h3F000000, 1'b1, 32'h0, 3'b001, 32'h0, 3'b001},
    '{32'h3F400000, 1'b1, 32'h1, 3'b001, 32'h1, 3'b001},
    '{32'h7F800000, 1'b0, 32'hFFFFFFFF, 3'b100, 32'h7FFFFFFF, 3'b100},
    '{32'h40600000, 1'b1, 32'h4, 3'b001, 32'h4, 3'b001}
  };
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, out_cyc = 0, n_out = 0, n0 = 0, sent = 0;
  bit acc, rdy_low;
  logic [31:0] cur_a = '0;
  bit cur_rnd;
  exp_t cur_e;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  function automatic void ref_model(input logic [31:0] x, input bit r, input bit sg,
                                    output logic [31:0] zo, output logic [2:0] fo);
    longint m, q, rem, half, mag, maxp, minn;
    int e, k;
    bit frac, up;
    maxp = sg ? 64'h7FFFFFFF : 64'hFFFFFFFF;
    minn = sg ? 64'h80000000 : 64'h0;
    e = int'(x[30:23]);
    zo = '0;
    fo = 3'b000;
    if (e == 255) begin
      fo = x[22:0] != 0 ? 3'b010 : 3'b100;
      zo = (x[22:0] == 0 && x[31]) ? minn[31:0] : maxp[31:0];
      return;
    end
    if (e == 0) begin
      fo = {2'b00, x[22:0] != 0};
      return;
    end
    m = longint'({1'b1, x[22:0]});
    frac = 1'b0;
    up = 1'b0;
    if (e >= 150) mag = (e - 150 > 30) ? (longint'(1) << 40) : (m << (e - 150));
    else begin
      k = 150 - e;
      if (k > 30) begin
        q = 0;
        frac = 1'b1;
      end else begin
        q = m >> k;
        rem = m - (q << k);
        half = longint'(1) << (k - 1);
        frac = rem != 0;
        up = r && (rem > half || (rem == half && q % 2 == 1));
      end
      mag = q + longint'(up);
    end
    if (!x[31]) begin
      zo = mag > maxp ? maxp[31:0] : mag[31:0];
      fo = mag > maxp ? 3'b100 : {2'b00, frac};
    end else if (mag == 0) fo = {2'b00, frac};
    else if (mag > minn) begin
      zo = minn[31:0];
      fo = 3'b100;
    end else begin
      zo = 32'(-mag);
      fo = {2'b00, frac};
    end
  endfunction
  function automatic exp_t ref_both(input logic [31:0] x, input bit r);
    exp_t e;
    ref_model(x, r, 1'b0, e.z_u, e.f_u);
    ref_model(x, r, 1'b1, e.z_s, e.f_s);
    return e;
  endfunction
  function automatic logic [31:0] rand_float();
    logic [31:0] x;
    int k, s;
    x = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) begin
      s = $urandom_range(0, 3);
      x[30:23] = s < 2 ? 8'hFF : 8'h00;
      if (s[0]) x[22:0] = '0;
    end else if (k < 3) begin
      s = $urandom_range(0, 22);
      x[30:23] = 8'(127 + s);
      x[22:0] = x[22:0] & ~((23'd1 << (22 - s)) - 23'd1);
    end else x[30:23] = 8'($urandom_range(118, 162));
    return x;
  endfunction
  task automatic set_op();
    cur_a = rand_float();
    cur_rnd = 1'($urandom_range(0, 1));
    cur_e = ref_both(cur_a, cur_rnd);
  endtask
  task automatic set_dir(input dir_t d);
    cur_a = d.a;
    cur_rnd = d.r;
    cur_e = '{d.zu, d.fu, d.zs, d.fs};
  endtask
  task automatic step(input bit iv, input bit ordy, output bit ac);
    exp_t e;
    @(negedge clk);
    in_valid = iv;
    a = cur_a;
    rnd = cur_rnd;
    out_ready = ordy;
    #1;
    if (!in_ready_u) rdy_low = 1'b1;
    if (out_valid_u && !ordy && sb.size() > 0) check("hold_z", z_u, sb[0].z_u);
    if (out_valid_u && ordy) begin
      if (sb.size() == 0) check("spurious_ov", out_valid_u, 32'd0);
      else begin
        e = sb.pop_front();
        check("z_u", z_u, e.z_u);
        check("f_u", {ovf_u, inv_u, inx_u}, e.f_u);
        check("z_s", z_s, e.z_s);
        check("f_s", {ovf_s, inv_s, inx_s}, e.f_s);
        check("ov_s", out_valid_s, 32'd1);
        n_out++;
        out_cyc = cyc;
      end
    end
    ac = iv && in_ready_u;
    if (ac) begin
      sb.push_back(cur_e);
      acc_cyc = cyc;
    end
    cyc++;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 1'b1, acc);
    check("drain", sb.size(), 32'd0);
  endtask
  task automatic lat_test(input string tag);
    set_dir(dirs[0]);
    step(1'b1, 1'b1, acc);
    check("lat_acc", acc, 32'd1);
    n0 = n_out;
    for (int i = 0; i < 10 && n_out == n0; i++) step(1'b0, 1'b1, acc);
    check(tag, out_cyc - acc_cyc, 32'd3);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ov", out_valid_u, 32'd0);
    check("rst_z", z_u, 32'd0);
    check("rst_flags", {ovf_u, inv_u, inx_u, ovf_s, inv_s, inx_s}, 32'd0);
    check("rst_rdy", in_ready_u, 32'd1);
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", in_ready_u, 32'd1);
    lat_test("latency");
    foreach (dirs[i]) begin
      set_dir(dirs[i]);
      step(1'b1, 1'b1, acc);
    end
    drain();
    rdy_low = 1'b0;
    sent = 0;
    n0 = n_out;
    set_op();
    for (int t = 0; t < 40 && (sent < 6 || sb.size() > 0); t++) begin
      step(sent < 6, !(t >= 2 && t <= 6), acc);
      if (acc) begin
        sent++;
        set_op();
      end
    end
    check("stall_rdy_low", rdy_low, 32'd1);
    check("stall_cnt", n_out - n0, 32'd6);
    for (int i = 0; i < 3; i++) begin
      set_op();
      step(1'b1, 1'b1, acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_ov", out_valid_u, 32'd0);
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, acc);
      check("rst_no_stale", out_valid_u | out_valid_s, 32'd0);
    end
    lat_test("latency_after_rst");
    sent = 0;
    n0 = n_out;
    set_op();
    for (int t = 0; t < 60000 && (sent < 10000 || sb.size() > 0); t++) begin
      step(sent < 10000 && $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, acc);
      if (acc) begin
        sent++;
        set_op();
      end
    end
    check("rand_cnt", n_out - n0, 32'd10000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
